// File: rtl/mb_bus_pkg.sv
// Shared definitions for the motherboard cycle bridge: FSM encoding,
// counter sizing helper and RW polarity constants.
package mb_bus_pkg;

  typedef enum logic [3:0] {
    ST_IDLE,
    ST_ARM,
    ST_S2,
    ST_S3,
    ST_WAIT,
    ST_DATA,
    ST_ENDC,
    ST_ERR,
    ST_REARM
  } mb_state_e;

  localparam int unsigned TIMEOUT_C7M_DEF = 512;
  localparam int unsigned TO_CNT_W        = $clog2(TIMEOUT_C7M_DEF + 1);

  localparam logic RW_READ  = 1'b1;
  localparam logic RW_WRITE = 1'b0;

  // Bits needed to hold 0..max_val inclusive.
  function automatic int unsigned cnt_width(input int unsigned max_val);
    return (max_val < 1) ? 1 : $clog2(max_val + 1);
  endfunction

endpackage

// File: rtl/c7m_edge_sync.sv
// Brings C7M into the CLK domain and emits one-CLK rise/fall pulses,
// SYNC_STAGES+1 CLK after the C7M edge.
module c7m_edge_sync #(
  parameter int unsigned SYNC_STAGES = 2
) (
  input  logic clk_i,
  input  logic rst_ni,
  input  logic c7m_i,
  output logic c7r_o,
  output logic c7f_o
);

  localparam int unsigned NS = (SYNC_STAGES < 2) ? 2 : SYNC_STAGES;

  logic [NS-1:0] sync_q;
  logic          prev_q;
  logic          c7r_q;
  logic          c7f_q;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      sync_q <= '0;
      prev_q <= 1'b0;
      c7r_q  <= 1'b0;
      c7f_q  <= 1'b0;
    end else begin
      sync_q <= {sync_q[NS-2:0], c7m_i};
      prev_q <= sync_q[NS-1];
      c7r_q  <= sync_q[NS-1] & ~prev_q;
      c7f_q  <= ~sync_q[NS-1] & prev_q;
    end
  end

  assign c7r_o = c7r_q;
  assign c7f_o = c7f_q;

endmodule

// File: rtl/mb_cycle_bridge.sv
// Turns an accelerator bus request into a 68000-timed motherboard cycle
// aligned to C7M and returns DSACK or BERR to the accelerator.
module mb_cycle_bridge
  import mb_bus_pkg::*;
#(
  parameter int unsigned SYNC_STAGES = 2,
  parameter int unsigned TIMEOUT_C7M = 512,
  parameter int unsigned REARM_C7M   = 1
) (
  input  logic CLK,
  input  logic RESET_n,
  input  logic C7M,
  input  logic CPU_AS_n,
  input  logic CPU_RW,
  input  logic CPU_UDS_n,
  input  logic CPU_LDS_n,
  input  logic MB_SEL,
  input  logic MB_DTACK_n,
  input  logic M6800_DTACK_n,
  input  logic MB_BERR_n,
  output logic AS_CPU_n,
  output logic UDS_n,
  output logic LDS_n,
  output logic RW,
  output logic DATA_LE,
  output logic DATA_OE,
  output logic CPU_DSACK_n,
  output logic CPU_BERR_n
);

  localparam int unsigned TO_W   = cnt_width(TIMEOUT_C7M);
  localparam int unsigned RE_MAX = (REARM_C7M < 1) ? 1 : REARM_C7M;
  localparam int unsigned RE_W   = cnt_width(RE_MAX);

  logic c7r;
  logic c7f;

  c7m_edge_sync #(
    .SYNC_STAGES(SYNC_STAGES)
  ) u_sync (
    .clk_i (CLK),
    .rst_ni(RESET_n),
    .c7m_i (C7M),
    .c7r_o (c7r),
    .c7f_o (c7f)
  );

  mb_state_e       state_q, state_d;
  logic            as_q, as_d;
  logic            uds_q, uds_d;
  logic            lds_q, lds_d;
  logic            rw_q, rw_d;
  logic            le_q, le_d;
  logic            oe_q, oe_d;
  logic            dsack_q, dsack_d;
  logic            berr_q, berr_d;
  logic            rw_l_q, rw_l_d;
  logic            uds_l_q, uds_l_d;
  logic            lds_l_q, lds_l_d;
  logic            abort_q, abort_d;
  logic [TO_W-1:0] to_cnt_q, to_cnt_d;
  logic [RE_W-1:0] re_cnt_q, re_cnt_d;

  logic            aborted;
  logic            dtack;
  logic [TO_W-1:0] to_inc;

  always_ff @(posedge CLK or negedge RESET_n) begin
    if (!RESET_n) begin
      state_q  <= ST_IDLE;
      as_q     <= 1'b1;
      uds_q    <= 1'b1;
      lds_q    <= 1'b1;
      rw_q     <= 1'b1;
      le_q     <= 1'b0;
      oe_q     <= 1'b0;
      dsack_q  <= 1'b1;
      berr_q   <= 1'b1;
      rw_l_q   <= 1'b1;
      uds_l_q  <= 1'b1;
      lds_l_q  <= 1'b1;
      abort_q  <= 1'b0;
      to_cnt_q <= '0;
      re_cnt_q <= '0;
    end else begin
      state_q  <= state_d;
      as_q     <= as_d;
      uds_q    <= uds_d;
      lds_q    <= lds_d;
      rw_q     <= rw_d;
      le_q     <= le_d;
      oe_q     <= oe_d;
      dsack_q  <= dsack_d;
      berr_q   <= berr_d;
      rw_l_q   <= rw_l_d;
      uds_l_q  <= uds_l_d;
      lds_l_q  <= lds_l_d;
      abort_q  <= abort_d;
      to_cnt_q <= to_cnt_d;
      re_cnt_q <= re_cnt_d;
    end
  end

  // Once S2 is entered the motherboard cycle always runs to completion;
  // an accelerator that has dropped AS just gets no DSACK/BERR.
  always_comb begin
    state_d  = state_q;
    as_d     = as_q;
    uds_d    = uds_q;
    lds_d    = lds_q;
    rw_d     = rw_q;
    le_d     = 1'b0;
    oe_d     = oe_q;
    dsack_d  = dsack_q;
    berr_d   = berr_q;
    rw_l_d   = rw_l_q;
    uds_l_d  = uds_l_q;
    lds_l_d  = lds_l_q;
    abort_d  = abort_q;
    to_cnt_d = to_cnt_q;
    re_cnt_d = re_cnt_q;

    aborted = abort_q | CPU_AS_n;
    dtack   = ~MB_DTACK_n | ~M6800_DTACK_n;
    to_inc  = (to_cnt_q == TO_W'(TIMEOUT_C7M)) ? to_cnt_q : to_cnt_q + 1'b1;

    case (state_q)
      ST_IDLE: begin
        abort_d = 1'b0;
        if (!CPU_AS_n && MB_SEL) begin
          state_d = ST_ARM;
          rw_l_d  = CPU_RW;
          uds_l_d = CPU_UDS_n;
          lds_l_d = CPU_LDS_n;
        end
      end

      ST_ARM: begin
        if (CPU_AS_n) begin
          state_d = ST_IDLE;
        end else if (c7r) begin
          state_d = ST_S2;
          rw_d    = rw_l_q;
          oe_d    = (rw_l_q == RW_WRITE);
        end
      end

      ST_S2: begin
        abort_d = aborted;
        if (c7f) begin
          state_d = ST_S3;
          as_d    = 1'b0;
          if (rw_l_q == RW_READ) begin
            uds_d = uds_l_q;
            lds_d = lds_l_q;
          end
        end
      end

      ST_S3: begin
        abort_d = aborted;
        if (c7r) begin
          state_d = ST_WAIT;
          if (rw_l_q == RW_WRITE) begin
            uds_d = uds_l_q;
            lds_d = lds_l_q;
          end
        end
      end

      // Bus error outranks DTACK; timeout fires on the TIMEOUT_C7M-th empty c7f.
      ST_WAIT: begin
        abort_d = aborted;
        if (c7f) begin
          if (!MB_BERR_n || (!dtack && to_inc == TO_W'(TIMEOUT_C7M))) begin
            to_cnt_d = '0;
            as_d     = 1'b1;
            uds_d    = 1'b1;
            lds_d    = 1'b1;
            oe_d     = 1'b0;
            if (aborted) begin
              rw_d    = 1'b1;
              state_d = ST_REARM;
            end else begin
              berr_d  = 1'b0;
              state_d = ST_ERR;
            end
          end else if (dtack) begin
            to_cnt_d = '0;
            state_d  = ST_DATA;
          end else begin
            to_cnt_d = to_inc;
          end
        end
      end

      ST_DATA: begin
        abort_d = aborted;
        if (c7f) begin
          le_d  = (rw_l_q == RW_READ);
          as_d  = 1'b1;
          uds_d = 1'b1;
          lds_d = 1'b1;
          oe_d  = 1'b0;
          if (aborted) begin
            rw_d    = 1'b1;
            state_d = ST_REARM;
          end else begin
            dsack_d = 1'b0;
            state_d = ST_ENDC;
          end
        end
      end

      ST_ENDC: begin
        if (CPU_AS_n) begin
          dsack_d = 1'b1;
          rw_d    = 1'b1;
          state_d = ST_REARM;
        end
      end

      ST_ERR: begin
        if (CPU_AS_n) begin
          berr_d  = 1'b1;
          rw_d    = 1'b1;
          state_d = ST_REARM;
        end
      end

      // Keeps AS high long enough for the 6800 block to drop its DTACK.
      ST_REARM: begin
        if (c7r) begin
          if (re_cnt_q == RE_W'(RE_MAX - 1)) begin
            re_cnt_d = '0;
            state_d  = ST_IDLE;
          end else begin
            re_cnt_d = re_cnt_q + 1'b1;
          end
        end
      end

      default: state_d = ST_IDLE;
    endcase
  end

  assign AS_CPU_n    = as_q;
  assign UDS_n       = uds_q;
  assign LDS_n       = lds_q;
  assign RW          = rw_q;
  assign DATA_LE     = le_q;
  assign DATA_OE     = oe_q;
  assign CPU_DSACK_n = dsack_q;
  assign CPU_BERR_n  = berr_q;

endmodule

// File: tb/tb_mb_cycle_bridge.sv
// Directed bench for mb_cycle_bridge: default instance plus a short-timeout
// instance sharing the same stimulus.
module tb_mb_cycle_bridge;

  logic CLK = 1'b0;
  logic C7M = 1'b0;
  logic RESET_n;
  logic CPU_AS_n, CPU_RW, CPU_UDS_n, CPU_LDS_n, MB_SEL;
  logic MB_DTACK_n, M6800_DTACK_n, MB_BERR_n;

  logic as_a, uds_a, lds_a, rw_a, le_a, oe_a, dsack_a, berr_a;
  logic as_b, uds_b, lds_b, rw_b, le_b, oe_b, dsack_b, berr_b;

  int n_chk = 0;
  int n_bad = 0;
  int le_cnt = 0;
  int dsack_cnt = 0;

  always #5 CLK = ~CLK;
  initial begin
    #2;
    forever #70 C7M = ~C7M;
  end

  mb_cycle_bridge dut_a (
    .CLK(CLK), .RESET_n(RESET_n), .C7M(C7M),
    .CPU_AS_n(CPU_AS_n), .CPU_RW(CPU_RW), .CPU_UDS_n(CPU_UDS_n), .CPU_LDS_n(CPU_LDS_n),
    .MB_SEL(MB_SEL), .MB_DTACK_n(MB_DTACK_n), .M6800_DTACK_n(M6800_DTACK_n),
    .MB_BERR_n(MB_BERR_n),
    .AS_CPU_n(as_a), .UDS_n(uds_a), .LDS_n(lds_a), .RW(rw_a),
    .DATA_LE(le_a), .DATA_OE(oe_a), .CPU_DSACK_n(dsack_a), .CPU_BERR_n(berr_a)
  );

  mb_cycle_bridge #(.TIMEOUT_C7M(8)) dut_b (
    .CLK(CLK), .RESET_n(RESET_n), .C7M(C7M),
    .CPU_AS_n(CPU_AS_n), .CPU_RW(CPU_RW), .CPU_UDS_n(CPU_UDS_n), .CPU_LDS_n(CPU_LDS_n),
    .MB_SEL(MB_SEL), .MB_DTACK_n(MB_DTACK_n), .M6800_DTACK_n(M6800_DTACK_n),
    .MB_BERR_n(MB_BERR_n),
    .AS_CPU_n(as_b), .UDS_n(uds_b), .LDS_n(lds_b), .RW(rw_b),
    .DATA_LE(le_b), .DATA_OE(oe_b), .CPU_DSACK_n(dsack_b), .CPU_BERR_n(berr_b)
  );

  always @(posedge CLK) begin
    if (le_a) le_cnt = le_cnt + 1;
    if (!dsack_a) dsack_cnt = dsack_cnt + 1;
  end

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // Land just after the DUT register update caused by the next C7M edge.
  task automatic step_r();
    @(posedge C7M);
    repeat (4) @(posedge CLK);
    #1;
  endtask

  task automatic step_f();
    @(negedge C7M);
    repeat (4) @(posedge CLK);
    #1;
  endtask

  task automatic idle_inputs();
    CPU_AS_n = 1'b1; CPU_RW = 1'b1; CPU_UDS_n = 1'b1; CPU_LDS_n = 1'b1;
    MB_SEL = 1'b0; MB_DTACK_n = 1'b1; M6800_DTACK_n = 1'b1; MB_BERR_n = 1'b1;
  endtask

  task automatic do_reset();
    RESET_n = 1'b0;
    idle_inputs();
    repeat (3) @(posedge CLK);
    #1 RESET_n = 1'b1;
    repeat (20) @(posedge CLK);
    step_f();
  endtask

  task automatic start_cycle(input logic rw, input logic uds, input logic lds);
    CPU_RW = rw; CPU_UDS_n = uds; CPU_LDS_n = lds; MB_SEL = 1'b1; CPU_AS_n = 1'b0;
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int base_le;
    int base_ds;
    int cnt;

    RESET_n = 1'b0;
    idle_inputs();
    #20;
    check_eq("rst_outs", {as_a, uds_a, lds_a, rw_a, le_a, oe_a, dsack_a, berr_a}, 8'b1111_0011);

    // Read, MB DTACK on the 2nd c7f in WAIT
    do_reset();
    base_le = le_cnt;
    start_cycle(1'b1, 1'b0, 1'b0);
    step_r();
    check_eq("rd_s2", {as_a, rw_a, oe_a}, 3'b110);
    step_f();
    check_eq("rd_s3_strobes", {as_a, uds_a, lds_a}, 3'b000);
    step_r();
    step_f();
    check_eq("rd_wait1", {as_a, dsack_a, berr_a}, 3'b011);
    MB_DTACK_n = 1'b0;
    step_f();
    check_eq("rd_data", {as_a, le_a, dsack_a}, 3'b001);
    step_f();
    check_eq("rd_exit", {as_a, uds_a, lds_a, le_a, dsack_a}, 5'b11110);
    @(posedge CLK); #1;
    check_eq("rd_le_pulse_end", le_a, 1'b0);
    MB_DTACK_n = 1'b1;
    repeat (5) @(posedge CLK); #1;
    check_eq("rd_dsack_hold", dsack_a, 1'b0);
    CPU_AS_n = 1'b1;
    @(posedge CLK); #1;
    check_eq("rd_dsack_rel", {dsack_a, rw_a}, 2'b11);
    check_eq("rd_le_count", 32'(le_cnt - base_le), 32'd1);

    // Word write
    do_reset();
    base_le = le_cnt;
    start_cycle(1'b0, 1'b0, 1'b0);
    step_r();
    check_eq("wr_arm_exit", {as_a, rw_a, oe_a}, 3'b101);
    step_f();
    check_eq("wr_s3_no_strobe", {as_a, uds_a, lds_a}, 3'b011);
    step_r();
    check_eq("wr_strobes", {as_a, uds_a, lds_a, oe_a}, 4'b0001);
    MB_DTACK_n = 1'b0;
    step_f();
    step_f();
    check_eq("wr_exit", {as_a, oe_a, le_a, dsack_a}, 4'b1000);
    check_eq("wr_no_le", 32'(le_cnt - base_le), 32'd0);
    MB_DTACK_n = 1'b1;
    CPU_AS_n = 1'b1;
    @(posedge CLK); #1;
    check_eq("wr_dsack_rel", dsack_a, 1'b1);

    // 6800 DTACK after 10 C7M, then a queued cycle
    do_reset();
    start_cycle(1'b1, 1'b0, 1'b1);
    step_r();
    step_f();
    step_r();
    repeat (10) step_f();
    check_eq("m68_wait10", {as_a, dsack_a, berr_a}, 3'b011);
    M6800_DTACK_n = 1'b0;
    step_f();
    step_f();
    check_eq("m68_exit", {as_a, dsack_a}, 2'b10);
    M6800_DTACK_n = 1'b1;
    cnt = 0;
    CPU_AS_n = 1'b1;
    @(posedge CLK); #1;
    cnt++;
    check_eq("m68_dsack_rel", dsack_a, 1'b1);
    CPU_AS_n = 1'b0;
    while (as_a && cnt < 200) begin
      @(posedge CLK); #1;
      cnt++;
    end
    check_eq("m68_as_high_min", 32'(cnt >= 14), 32'd1);
    check_eq("m68_as_high_clk", 32'(cnt), 32'd28);

    // BERR and DTACK on the same c7f
    do_reset();
    base_ds = dsack_cnt;
    start_cycle(1'b1, 1'b0, 1'b0);
    step_r();
    step_f();
    step_r();
    MB_BERR_n = 1'b0;
    MB_DTACK_n = 1'b0;
    step_f();
    check_eq("berr_win", {berr_a, dsack_a, as_a, uds_a, lds_a}, 5'b01111);
    MB_BERR_n = 1'b1;
    MB_DTACK_n = 1'b1;
    step_f();
    check_eq("berr_hold", berr_a, 1'b0);
    CPU_AS_n = 1'b1;
    @(posedge CLK); #1;
    check_eq("berr_rel", berr_a, 1'b1);
    check_eq("berr_no_dsack", 32'(dsack_cnt - base_ds), 32'd0);

    // Timeout with TIMEOUT_C7M=8
    do_reset();
    start_cycle(1'b1, 1'b0, 1'b0);
    step_r();
    step_f();
    step_r();
    repeat (7) step_f();
    check_eq("to_before", {berr_b, as_b}, 2'b10);
    step_f();
    check_eq("to_fire", {berr_b, as_b, uds_b, lds_b}, 4'b0111);
    check_eq("to_default_inst", berr_a, 1'b1);
    CPU_AS_n = 1'b1;
    @(posedge CLK); #1;
    check_eq("to_rel", berr_b, 1'b1);

    // Accelerator drops AS in WAIT
    do_reset();
    base_ds = dsack_cnt;
    start_cycle(1'b1, 1'b0, 1'b0);
    step_r();
    step_f();
    step_r();
    CPU_AS_n = 1'b1;
    step_f();
    MB_DTACK_n = 1'b0;
    step_f();
    check_eq("abt_data_as", as_a, 1'b0);
    step_f();
    check_eq("abt_exit", {as_a, uds_a, lds_a, berr_a}, 4'b1111);
    MB_DTACK_n = 1'b1;
    repeat (10) @(posedge CLK); #1;
    check_eq("abt_no_dsack", 32'(dsack_cnt - base_ds), 32'd0);

    // Accelerator drops AS in ARM
    do_reset();
    start_cycle(1'b0, 1'b0, 1'b0);
    @(posedge CLK); #1;
    CPU_AS_n = 1'b1;
    step_r();
    step_f();
    check_eq("arm_abort", {as_a, uds_a, rw_a, oe_a}, 4'b1110);

    // Async reset in S3 of a write
    do_reset();
    start_cycle(1'b0, 1'b0, 1'b0);
    step_r();
    step_f();
    check_eq("rst_pre", {as_a, rw_a, oe_a}, 3'b001);
    RESET_n = 1'b0;
    #1;
    check_eq("rst_mid", {as_a, uds_a, lds_a, rw_a, le_a, oe_a, dsack_a, berr_a}, 8'b1111_0011);
    idle_inputs();
    #20;

    $display("test done: total=%0d bad=%0d", n_chk, n_bad);
    $finish;
  end

endmodule
